switch_debounce: RTL and testbench

SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

---
 rtl/switch_debounce_pkg.sv | 11 +
 rtl/switch_debounce_bit.sv | 71 +++++++
 rtl/switch_debounce.sv | 47 ++++
 tb/tb_switch_debounce.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/switch_debounce_pkg.sv
// switch_debounce_pkg: shared types and constants for the switch conditioning block
package switch_debounce_pkg;

    typedef enum logic {
        Stable   = 1'b0,
        Settling = 1'b1
    } debounce_state_t;

    localparam int DEBOUNCE_DEFAULT = 16;

endpackage

// File: rtl/switch_debounce_bit.sv
// debounce_bit: two-flop synchroniser, Stable/Settling FSM and hold counter for one switch
module debounce_bit
    import switch_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic Clock,
    input  logic nReset,
    input  logic SwIn,
    output logic SwOut
);

    localparam int CountWidth = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CountWidth-1:0] MaxCount = CountWidth'(DEBOUNCE_CYCLES);

    logic syncMeta;
    logic synced;
    debounce_state_t state;
    debounce_state_t stateNext;
    logic [CountWidth-1:0] count;
    logic [CountWidth-1:0] countNext;
    logic outNext;

    // Bring the asynchronous switch level into the clock domain
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            syncMeta <= 1'b0;
            synced   <= 1'b0;
        end else begin
            syncMeta <= SwIn;
            synced   <= syncMeta;
        end
    end

    // Debounce state, hold counter and accepted level
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state <= Stable;
            count <= '0;
            SwOut <= 1'b0;
        end else begin
            state <= stateNext;
            count <= countNext;
            SwOut <= outNext;
        end
    end

    // Accept a new level only after it has held for DEBOUNCE_CYCLES further cycles
    always_comb begin
        stateNext = state;
        countNext = count;
        outNext   = SwOut;
        if (state == Stable) begin
            countNext = '0;
            if (synced != SwOut) begin
                stateNext = Settling;
                countNext = CountWidth'(1);
            end
        end else if (synced == SwOut) begin
            stateNext = Stable;
            countNext = '0;
        end else if (count < MaxCount) begin
            countNext = count + CountWidth'(1);
        end else begin
            outNext   = synced;
            stateNext = Stable;
            countNext = '0;
        end
    end

endmodule

// File: rtl/switch_debounce.sv
// switch_debounce: per-bit synchronise and debounce of WIDTH switches; SWITCH_EDGE_EN adds Rise/Fall pulses
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int WIDTH           = 9,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic [WIDTH-1:0] SwIn,
    output logic [WIDTH-1:0] SwOut,
    output logic             Sw8
`ifdef SWITCH_EDGE_EN
    ,
    output logic [WIDTH-1:0] Rise,
    output logic [WIDTH-1:0] Fall
`endif
);

    for (genvar i = 0; i < WIDTH; i++) begin : gBit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) uBit (
            .Clock (Clock),
            .nReset(nReset),
            .SwIn  (SwIn[i]),
            .SwOut (SwOut[i])
        );
    end

    // Bit 8 is the processor's WAIT0/WAIT1 condition
    assign Sw8 = SwOut[8];

`ifdef SWITCH_EDGE_EN
    logic [WIDTH-1:0] swOutPrev;

    // Remember last cycle's debounced levels so transitions show for one cycle
    always_ff @(posedge Clock) begin
        if (!nReset) swOutPrev <= '0;
        else         swOutPrev <= SwOut;
    end

    assign Rise = SwOut & ~swOutPrev;
    assign Fall = ~SwOut & swOutPrev;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// tb_switch_debounce: directed and random checks of switch_debounce against a sample-window model
module tb_switch_debounce;

    localparam int W = 9;
    localparam int N = 4;

    logic         Clock = 1'b0;
    logic         nReset;
    logic [W-1:0] SwIn;
    logic [W-1:0] SwOut;
    logic         Sw8;
`ifdef SWITCH_EDGE_EN
    logic [W-1:0] Rise;
    logic [W-1:0] Fall;
`endif

    int compared   = 0;
    int mismatched = 0;

    switch_debounce #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .Clock (Clock),
        .nReset(nReset),
        .SwIn  (SwIn),
        .SwOut (SwOut),
        .Sw8   (Sw8)
`ifdef SWITCH_EDGE_EN
        ,
        .Rise  (Rise),
        .Fall  (Fall)
`endif
    );

    always #5 Clock = ~Clock;

    // Model: hist[k] is SwIn sampled k edges ago (cleared by reset). The level seen
    // after synchronisation is hist[2]; an output bit flips once its last N+1 synced
    // samples all disagree with it.
    logic [W-1:0] hist [0:N+2];
    logic [W-1:0] expOut;
    logic [W-1:0] expPrev;
    logic         allDiff;

    always @(posedge Clock) begin
        expPrev = expOut;
        if (!nReset) begin
            for (int k = 0; k <= N + 2; k++) hist[k] = '0;
            expOut  = '0;
            expPrev = '0;
        end else begin
            for (int k = N + 2; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = SwIn;
            for (int b = 0; b < W; b++) begin
                allDiff = 1'b1;
                for (int k = 2; k <= N + 2; k++)
                    if (hist[k][b] == expOut[b]) allDiff = 1'b0;
                if (allDiff) expOut[b] = ~expOut[b];
            end
        end
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag);
        @(posedge Clock);
        @(negedge Clock);
        check({tag, "_model_out"}, SwOut, expOut);
        check({tag, "_model_sw8"}, Sw8, expOut[8]);
`ifdef SWITCH_EDGE_EN
        check({tag, "_model_rise"}, Rise, expOut & ~expPrev);
        check({tag, "_model_fall"}, Fall, ~expOut & expPrev);
`endif
    endtask

    task automatic settle(input logic [W-1:0] v);
        SwIn = v;
        repeat (N + 4) step("settle");
    endtask

    initial begin
        nReset = 1'b0;
        SwIn   = '1;
        repeat (2) begin
            @(posedge Clock);
            @(negedge Clock);
            check("reset_out", SwOut, '0);
            check("reset_sw8", Sw8, '0);
        end
        nReset = 1'b1;
        for (int e = 1; e <= N + 3; e++) begin
            step("reset_release");
            check("reset_latency", SwOut, (e == N + 3) ? 9'h1FF : 9'h000);
        end

        settle('0);
        for (int e = 1; e <= N + 3; e++) begin
            SwIn = {1'b1, 8'($urandom)};
            step("clean_edge");
            check("clean_sw8", Sw8, (e == N + 3) ? 9'h001 : 9'h000);
        end

        settle('0);
        for (int e = 0; e < 4; e++) begin
            SwIn[8] = (e % 2 == 0);
            step("bounce");
            check("bounce_sw8", Sw8, '0);
        end
        SwIn[8] = 1'b1;
        for (int e = 1; e <= N + 3; e++) begin
            step("bounce_settle");
            check("bounce_settle_sw8", Sw8, (e == N + 3) ? 9'h001 : 9'h000);
        end

        settle('0);
        SwIn[3] = 1'b1;
        repeat (3) begin
            step("glitch_hi");
            check("glitch_bit3", SwOut & 9'h008, '0);
        end
        SwIn[3] = 1'b0;
        repeat (N + 4) begin
            step("glitch_lo");
            check("glitch_bit3", SwOut & 9'h008, '0);
        end
        SwIn[3] = 1'b1;
        for (int e = 1; e <= N + 3; e++) begin
            step("after_glitch");
            check("after_glitch_bit3", SwOut & 9'h008, (e == N + 3) ? 9'h008 : 9'h000);
        end

        settle('0);
        SwIn[0] = 1'b1;
        repeat (3) step("pre_reset");
        nReset = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        check("mid_reset_out", SwOut, '0);
        nReset = 1'b1;
        for (int e = 1; e <= N + 3; e++) begin
            step("post_reset");
            check("post_reset_bit0", SwOut & 9'h001, (e == N + 3) ? 9'h001 : 9'h000);
        end

`ifdef SWITCH_EDGE_EN
        settle('0);
        SwIn = 9'h005;
        for (int e = 1; e <= N + 4; e++) begin
            step("edge_rise");
            check("rise_pulse", Rise, (e == N + 3) ? 9'h005 : 9'h000);
            check("rise_no_fall", Fall, '0);
        end
        SwIn = 9'h000;
        for (int e = 1; e <= N + 4; e++) begin
            step("edge_fall");
            check("fall_pulse", Fall, (e == N + 3) ? 9'h005 : 9'h000);
            check("fall_no_rise", Rise, '0);
        end
`endif

        for (int c = 0; c < 400; c++) begin
            SwIn   = SwIn ^ W'($urandom & $urandom & $urandom);
            nReset = ($urandom_range(0, 60) != 0);
            step("random");
        end
        nReset = 1'b1;
        settle(W'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
